mybus_arbiter: RTL and testbench
================================

MYBUS_ARBITER -- requirements
Module: mybus_arbiter

Interface
REQ-001 Parameter: RD_TIMEOUT, default 16, cycles to wait for a read response before flagging an error.
REQ-002 clk  in  1  clock; all logic on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 h_valid/h_ready  in/out  1/1  host command handshake.
REQ-005 h_write, h_addr, h_wdata  in  1/8/8  host command: 1=write (wrCmd), 0=read (rdCmd); address; write data.
REQ-006 h_rvalid, h_rdata, h_rerr  out  1/8/1  one-cycle read completion: data, timeout flag.
REQ-007 v_valid/v_ready, v_addr, v_data  in/out/in/in  1/1/8/8  video engine vdoResp write channel.
REQ-008 s_valid/s_ready, s_addr, s_data  in/out/in/in  1/1/8/8  sensor-map engine smapResp write channel.
REQ-009 bus_mode, bus_addr, bus_data, bus_sel  out  3/8/8/1  drive to bus input port.
REQ-010 bus_mode_in, bus_data_in, bus_sel_in  in  3/8/1  bus output port monitor.
REQ-011 vdo_req_evt, smap_req_evt  out  1/1  one-cycle pulses forwarding bus vdoReq/smapReq.

Function
REQ-012 Transfer on a channel occurs in a cycle where valid and ready are both high; at most one ready high per cycle.
REQ-013 Ready is combinational from valid, arbiter state and FSM state; valid shall not depend on ready.
REQ-014 Arbitration round-robin among host, video, smap; after a grant the granted requester becomes lowest priority.
REQ-015 Transfer accepted in cycle N -> bus_sel high in cycle N+1 for exactly one cycle with registered mode/addr/data; bus_sel low otherwise.
REQ-016 Mode codes: host write 000, host read 001 (bus_data=0), video 100, smap 110; 010/011/101/111 never driven.
REQ-017 FSM states IDLE, WAIT_RD; IDLE->WAIT_RD on host read transfer; WAIT_RD->IDLE on response match or timeout.
REQ-018 In WAIT_RD, h_ready held low; video and smap still arbitrated (host skipped).
REQ-019 Response match: bus_sel_in high and bus_mode_in==010 while in WAIT_RD; next cycle h_rvalid=1, h_rdata=captured bus_data_in, h_rerr=0.
REQ-020 Timeout counter starts at 0 on entering WAIT_RD, increments each cycle; on reaching RD_TIMEOUT with no match -> h_rvalid=1, h_rdata=0, h_rerr=1, return to IDLE.
REQ-021 Response in the same cycle the counter hits RD_TIMEOUT counts as a match (no error).
REQ-022 rdResp seen in IDLE is ignored (no h_rvalid).
REQ-023 vdo_req_evt=1 the cycle after bus_sel_in high with bus_mode_in==011; smap_req_evt likewise for 101; independent of FSM state.
REQ-024 Counter width ceil(log2(RD_TIMEOUT+1)); no wrap before timeout fires.

Reset
REQ-025 In reset: bus_mode=000, bus_addr=0, bus_data=0, bus_sel=0, h_rvalid=0, h_rdata=0, h_rerr=0, evt outputs 0, all readies 0.
REQ-026 FSM to IDLE, timeout counter 0, round-robin pointer to host-highest (host>video>smap).
REQ-027 Reset during WAIT_RD abandons the read: no h_rvalid issued for it after reset release.

Structure
REQ-028 Package mybus_pkg holds the 3-bit bus mode enum (all eight codes), FSM state enum and default RD_TIMEOUT.
REQ-029 Arbitration in sub-module rr_arbiter3 (3 requests, one-hot grant, advance on accept).

Verification
REQ-030 Host write 0x5A @0x10, then read @0x10 -> bus_sel pulses mode 000 then 001; h_rvalid with h_rdata=0x5A, h_rerr=0.
REQ-031 Host, video, smap valid together continuously -> grants rotate host, video, smap, host; one bus_sel per grant, no gaps.
REQ-032 Host read issued so bus rdResp collides with vdoReq (response lost) -> vdo_req_evt pulse; after RD_TIMEOUT=16 cycles h_rvalid=1, h_rerr=1, h_rdata=0.
REQ-033 Video write during WAIT_RD -> v_ready granted, bus_sel mode 100; h_ready stays 0 until read completes.
REQ-034 rst asserted 2 cycles after host read accepted -> all outputs reset values; no h_rvalid after release.
REQ-035 Bus smapReq (101) pulse -> smap_req_evt high exactly one cycle, FSM state unchanged.

Source files
------------

// File: rtl/mybus_pkg.sv
// ============================================================================
// mybus_pkg : shared bus mode codes, read FSM states and defaults for mybus
// Rev 1.0
// ============================================================================
`default_nettype none

package mybus_pkg;

  typedef enum logic [2:0] {
    MODE_HWR     = 3'b000,
    MODE_HRD     = 3'b001,
    MODE_RDRESP  = 3'b010,
    MODE_VDOREQ  = 3'b011,
    MODE_VDO     = 3'b100,
    MODE_SMAPREQ = 3'b101,
    MODE_SMAP    = 3'b110,
    MODE_RSVD    = 3'b111
  } busMode_t;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_WAIT_RD = 1'b1
  } rdState_t;

  localparam int c_RD_TIMEOUT_DEFAULT = 16;

  // Counter must be able to hold the timeout value itself without wrapping.
  function automatic int cntWidth(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mybus_arbiter_rr.sv
// ============================================================================
// rr_arbiter3 : 3-requester round-robin arbiter, granted requester drops to
//               lowest priority when its grant is accepted
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter3 (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_req,
  input  logic       i_accept,
  output logic [2:0] o_grant
);

  logic [1:0] r_prio;
  logic [5:0] w_reqDbl;
  logic [2:0] w_rot;
  logic [2:0] w_rotGnt;
  logic [5:0] w_gntDbl;

  // Rotate so the highest-priority requester sits at bit 0, pick the lowest
  // set bit, then rotate the one-hot result back.
  assign w_reqDbl = {i_req, i_req};
  assign w_rot    = w_reqDbl[r_prio +: 3];
  assign w_rotGnt = w_rot & (~w_rot + 3'd1);
  assign w_gntDbl = {w_rotGnt, w_rotGnt} << r_prio;
  assign o_grant  = w_gntDbl[5:3];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= 2'd0;
    end else if (i_accept) begin
      if (o_grant[0])      r_prio <= 2'd1;
      else if (o_grant[1]) r_prio <= 2'd2;
      else                 r_prio <= 2'd0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mybus_arbiter.sv
// ============================================================================
// mybus_arbiter : arbitrates host/video/smap commands onto mybus and tracks
//                 outstanding host reads with a response timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module mybus_arbiter
  import mybus_pkg::*;
#(
  parameter int RD_TIMEOUT = c_RD_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       h_valid,
  output logic       h_ready,
  input  logic       h_write,
  input  logic [7:0] h_addr,
  input  logic [7:0] h_wdata,
  output logic       h_rvalid,
  output logic [7:0] h_rdata,
  output logic       h_rerr,
  input  logic       v_valid,
  output logic       v_ready,
  input  logic [7:0] v_addr,
  input  logic [7:0] v_data,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_addr,
  input  logic [7:0] s_data,
  output logic [2:0] bus_mode,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_data,
  output logic       bus_sel,
  input  logic [2:0] bus_mode_in,
  input  logic [7:0] bus_data_in,
  input  logic       bus_sel_in,
  output logic       vdo_req_evt,
  output logic       smap_req_evt
);

  localparam int                 c_CNT_W   = cntWidth(RD_TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(RD_TIMEOUT);

  rdState_t           r_state;
  rdState_t           w_stateNext;
  logic [c_CNT_W-1:0] r_cnt;
  logic               w_rdMatch;
  logic               w_rdTimeout;
  logic [2:0]         w_req;
  logic [2:0]         w_grant;
  logic               w_accept;

  busMode_t           r_busMode;
  logic [7:0]         r_busAddr;
  logic [7:0]         r_busData;
  logic               r_busSel;
  logic               r_hRvalid;
  logic [7:0]         r_hRdata;
  logic               r_hRerr;
  logic               r_vdoEvt;
  logic               r_smapEvt;

  // Host is withheld while a read is outstanding; nothing is granted in reset.
  assign w_req    = {s_valid, v_valid, h_valid && (r_state == ST_IDLE)} & {3{~rst}};
  assign w_accept = |w_grant;

  rr_arbiter3 u_rr (
    .clk      (clk),
    .rst      (rst),
    .i_req    (w_req),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  assign h_ready = w_grant[0];
  assign v_ready = w_grant[1];
  assign s_ready = w_grant[2];

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_rdMatch   = 1'b0;
    w_rdTimeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant[0] && !h_write) w_stateNext = ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (bus_sel_in && (bus_mode_in == MODE_RDRESP)) begin
          w_rdMatch   = 1'b1;
          w_stateNext = ST_IDLE;
        end else if (r_cnt == c_CNT_MAX) begin
          w_rdTimeout = 1'b1;
          w_stateNext = ST_IDLE;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || (r_state != ST_WAIT_RD) || (w_stateNext != ST_WAIT_RD)) r_cnt <= '0;
    else                                                              r_cnt <= r_cnt + c_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busMode <= MODE_HWR;
      r_busAddr <= '0;
      r_busData <= '0;
      r_busSel  <= 1'b0;
    end else begin
      r_busSel <= w_accept;
      if (w_grant[0]) begin
        r_busMode <= h_write ? MODE_HWR : MODE_HRD;
        r_busAddr <= h_addr;
        r_busData <= h_write ? h_wdata : 8'h00;
      end else if (w_grant[1]) begin
        r_busMode <= MODE_VDO;
        r_busAddr <= v_addr;
        r_busData <= v_data;
      end else if (w_grant[2]) begin
        r_busMode <= MODE_SMAP;
        r_busAddr <= s_addr;
        r_busData <= s_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hRvalid <= 1'b0;
      r_hRdata  <= '0;
      r_hRerr   <= 1'b0;
      r_vdoEvt  <= 1'b0;
      r_smapEvt <= 1'b0;
    end else begin
      r_hRvalid <= w_rdMatch || w_rdTimeout;
      r_hRdata  <= w_rdMatch ? bus_data_in : 8'h00;
      r_hRerr   <= w_rdTimeout;
      r_vdoEvt  <= bus_sel_in && (bus_mode_in == MODE_VDOREQ);
      r_smapEvt <= bus_sel_in && (bus_mode_in == MODE_SMAPREQ);
    end
  end

  assign bus_mode     = r_busMode;
  assign bus_addr     = r_busAddr;
  assign bus_data     = r_busData;
  assign bus_sel      = r_busSel;
  assign h_rvalid     = r_hRvalid;
  assign h_rdata      = r_hRdata;
  assign h_rerr       = r_hRerr;
  assign vdo_req_evt  = r_vdoEvt;
  assign smap_req_evt = r_smapEvt;

endmodule

`default_nettype wire

// File: tb/tb_mybus_arbiter.sv
// ============================================================================
// tb_mybus_arbiter : directed + random stimulus against a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mybus_arbiter;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       h_valid, h_write, v_valid, s_valid, bus_sel_in;
  logic [7:0] h_addr, h_wdata, v_addr, v_data, s_addr, s_data, bus_data_in;
  logic [2:0] bus_mode_in;
  logic       h_ready, v_ready, s_ready, h_rvalid, h_rerr, bus_sel;
  logic       vdo_req_evt, smap_req_evt;
  logic [7:0] h_rdata, bus_addr, bus_data;
  logic [2:0] bus_mode;

  always #5 clk = ~clk;

  mybus_arbiter #(.RD_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .h_valid(h_valid), .h_ready(h_ready), .h_write(h_write),
    .h_addr(h_addr), .h_wdata(h_wdata),
    .h_rvalid(h_rvalid), .h_rdata(h_rdata), .h_rerr(h_rerr),
    .v_valid(v_valid), .v_ready(v_ready), .v_addr(v_addr), .v_data(v_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_data(s_data),
    .bus_mode(bus_mode), .bus_addr(bus_addr), .bus_data(bus_data), .bus_sel(bus_sel),
    .bus_mode_in(bus_mode_in), .bus_data_in(bus_data_in), .bus_sel_in(bus_sel_in),
    .vdo_req_evt(vdo_req_evt), .smap_req_evt(smap_req_evt)
  );

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;

  // Reference model: who was granted last, whether a read is outstanding and
  // in which cycle it started waiting, plus the outputs expected next cycle.
  bit         mBusy;
  int         mStart;
  int         mLast;
  bit         eAll;
  logic       eSel, eRv, eRerr, eVe, eSe;
  logic [2:0] eMode;
  logic [7:0] eAddr, eData, eRd;
  logic [2:0] lastGnt;

  task automatic checkVal(input string tag, input logic [7:0] act, input logic [7:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step;
    logic [2:0] req;
    logic [2:0] gnt;
    int         idx;
    #1;
    gnt = 3'b000;
    if (!rst) begin
      req = {s_valid, v_valid, h_valid && !mBusy};
      for (int k = 0; k < 3; k++) begin
        idx = (mLast + 1 + k) % 3;
        if (gnt == 3'b000 && req[idx]) gnt[idx] = 1'b1;
      end
    end
    checkVal("h_ready", 8'(h_ready), 8'(gnt[0]));
    checkVal("v_ready", 8'(v_ready), 8'(gnt[1]));
    checkVal("s_ready", 8'(s_ready), 8'(gnt[2]));

    if (rst) begin
      eAll = 1; eSel = 0; eMode = 3'd0; eAddr = 8'h00; eData = 8'h00;
      eRv = 0; eRd = 8'h00; eRerr = 0; eVe = 0; eSe = 0;
      mBusy = 0; mLast = 2;
    end else begin
      eAll = 0;
      eSel = |gnt;
      if (gnt[0]) begin
        eMode = h_write ? 3'd0 : 3'd1; eAddr = h_addr; eData = h_write ? h_wdata : 8'h00; mLast = 0;
      end else if (gnt[1]) begin
        eMode = 3'd4; eAddr = v_addr; eData = v_data; mLast = 1;
      end else if (gnt[2]) begin
        eMode = 3'd6; eAddr = s_addr; eData = s_data; mLast = 2;
      end
      eRv = 0; eRd = 8'h00; eRerr = 0;
      if (mBusy) begin
        if (bus_sel_in && bus_mode_in == 3'd2) begin
          eRv = 1; eRd = bus_data_in; mBusy = 0;
        end else if (cyc - mStart == TO) begin
          eRv = 1; eRerr = 1; mBusy = 0;
        end
      end
      if (gnt[0] && !h_write) begin
        mBusy = 1; mStart = cyc + 1;
      end
      eVe = bus_sel_in && bus_mode_in == 3'd3;
      eSe = bus_sel_in && bus_mode_in == 3'd5;
    end
    lastGnt = gnt;

    @(posedge clk);
    #1;
    cyc++;
    checkVal("bus_sel", 8'(bus_sel), 8'(eSel));
    if (eSel || eAll) begin
      checkVal("bus_mode", 8'(bus_mode), 8'(eMode));
      checkVal("bus_addr", bus_addr, eAddr);
      checkVal("bus_data", bus_data, eData);
    end
    checkVal("h_rvalid", 8'(h_rvalid), 8'(eRv));
    if (eRv || eAll) begin
      checkVal("h_rdata", h_rdata, eRd);
      checkVal("h_rerr", 8'(h_rerr), 8'(eRerr));
    end
    checkVal("vdo_req_evt", 8'(vdo_req_evt), 8'(eVe));
    checkVal("smap_req_evt", 8'(smap_req_evt), 8'(eSe));
  endtask

  initial begin
    rst = 1; h_valid = 0; h_write = 0; h_addr = 0; h_wdata = 0;
    v_valid = 0; v_addr = 0; v_data = 0; s_valid = 0; s_addr = 0; s_data = 0;
    bus_sel_in = 0; bus_mode_in = 0; bus_data_in = 0;
    mBusy = 0; mStart = 0; mLast = 2; lastGnt = 0; eAll = 1;
    @(posedge clk); #1;
    repeat (2) step;
    rst = 0;

    // Host write then read of the same location, bus answers with 0x5A
    h_valid = 1; h_write = 1; h_addr = 8'h10; h_wdata = 8'h5A; step;
    h_valid = 0; step;
    h_valid = 1; h_write = 0; step;
    h_valid = 0; repeat (3) step;
    bus_sel_in = 1; bus_mode_in = 3'b010; bus_data_in = 8'h5A; step;
    bus_sel_in = 0; repeat (2) step;

    // All three requesters continuously valid
    h_valid = 1; h_write = 1; h_addr = 8'h21; h_wdata = 8'h33;
    v_valid = 1; v_addr = 8'h42; v_data = 8'h99;
    s_valid = 1; s_addr = 8'h63; s_data = 8'hC3;
    repeat (7) step;
    h_valid = 0; v_valid = 0; s_valid = 0; step;

    // Read response lost to a colliding vdoReq -> timeout
    h_valid = 1; h_write = 0; h_addr = 8'h05; step;
    h_valid = 0; step;
    bus_sel_in = 1; bus_mode_in = 3'b011; bus_data_in = 8'hEE; step;
    bus_sel_in = 0; repeat (TO + 3) step;

    // Video traffic while a read is outstanding, host write waits
    h_valid = 1; h_write = 0; h_addr = 8'h07; step;
    h_write = 1; h_wdata = 8'h11; v_valid = 1; repeat (3) step;
    v_valid = 0; repeat (TO + 1) step;
    h_valid = 0; step;

    // Reset two cycles after a host read is accepted
    h_valid = 1; h_write = 0; h_addr = 8'h08; step;
    h_valid = 0; repeat (2) step;
    rst = 1; step;
    rst = 0; repeat (TO + 4) step;

    // smapReq forwarded as a one-cycle event from idle
    bus_sel_in = 1; bus_mode_in = 3'b101; step;
    bus_sel_in = 0; repeat (2) step;

    repeat (3000) begin
      rst = ($urandom_range(0, 299) == 0);
      if (!h_valid || lastGnt[0]) begin
        h_valid = ($urandom_range(0, 2) == 0); h_write = 1'($urandom);
        h_addr = 8'($urandom); h_wdata = 8'($urandom);
      end
      if (!v_valid || lastGnt[1]) begin
        v_valid = ($urandom_range(0, 2) == 0); v_addr = 8'($urandom); v_data = 8'($urandom);
      end
      if (!s_valid || lastGnt[2]) begin
        s_valid = ($urandom_range(0, 2) == 0); s_addr = 8'($urandom); s_data = 8'($urandom);
      end
      bus_sel_in  = ($urandom_range(0, 7) == 0);
      bus_mode_in = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'($urandom);
      bus_data_in = 8'($urandom);
      step;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

`default_nettype wire
